sram_1w1r_fifo_ctrl: RTL

Synchronous FIFO controller that wraps the 14x128 1-write/1-read OpenRAM macro and turns it into a valid/ready streaming FIFO. It drives macro port 0 (write) and port 1 (read) from a single clock, with both macro clocks tied to clk. It absorbs the macro's registered-input, negedge-access read latency with a 3-entry prefetch buffer, so the output stream can sustain 1 word/cycle.

---
 rtl/sram_fifo_pkg.sv | 43 ++++
 rtl/sram_fifo_obuf.sv | 76 +++++++
 rtl/sram_1w1r_fifo_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sram_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sram_fifo_pkg
// Shared constants for the SRAM-backed streaming FIFO controller built around
// the 14x128 1-write/1-read OpenRAM macro.
//
// Contents:
//   DATA_WIDTH     word width, fixed by the macro
//   ADDR_WIDTH     macro address width
//   DEPTH          number of macro words (1 << ADDR_WIDTH)
//   SRAM_RD_LAT    cycles from read issue to data sampled at a posedge
//   OBUF_DEPTH     prefetch buffer entries (one more than the read latency)
//   CNT_WIDTH      width of counters that range 0..DEPTH
//   LEVEL_WIDTH    width of the total occupancy count 0..DEPTH+OBUF_DEPTH
//   OBUF_PTR_WIDTH / OBUF_CNT_WIDTH  prefetch buffer index / count widths
//   obuf_next()    circular increment for prefetch buffer indices
// -----------------------------------------------------------------------------
package sram_fifo_pkg;

    localparam int DATA_WIDTH     = 14;
    localparam int ADDR_WIDTH     = 7;
    localparam int DEPTH          = 1 << ADDR_WIDTH;
    localparam int SRAM_RD_LAT    = 2;

    // One entry per read that can be in flight plus the entry being popped;
    // anything smaller stalls the output stream every few cycles.
    localparam int OBUF_DEPTH     = SRAM_RD_LAT + 1;

    localparam int CNT_WIDTH      = ADDR_WIDTH + 1;
    localparam int LEVEL_WIDTH    = ADDR_WIDTH + 2;
    localparam int OBUF_PTR_WIDTH = $clog2(OBUF_DEPTH);
    localparam int OBUF_CNT_WIDTH = $clog2(OBUF_DEPTH + 1);

    // OBUF_DEPTH is not a power of two, so the index wrap is explicit.
    function automatic logic [OBUF_PTR_WIDTH-1:0] obuf_next(
        input logic [OBUF_PTR_WIDTH-1:0] idx
    );
        if (idx == OBUF_PTR_WIDTH'(OBUF_DEPTH - 1)) begin
            return '0;
        end
        return idx + OBUF_PTR_WIDTH'(1);
    endfunction

endpackage

// File: rtl/sram_fifo_obuf.sv
// -----------------------------------------------------------------------------
// sram_fifo_obuf
// Small circular prefetch buffer that holds words already read out of the
// macro. It hides the macro read latency so the FIFO output can deliver one
// word per cycle. The caller never pushes into a full buffer (read issue is
// throttled on count plus reads in flight), so there is no overflow guard.
//
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset (clears indices and count)
//   push        write push_data at the tail this cycle
//   push_data   word captured from the macro read port
//   pop         remove the head word (ignored while empty)
//   head_data   word at the head of the buffer
//   count       number of valid entries, 0..OBUF_DEPTH
//   not_empty   count != 0
// -----------------------------------------------------------------------------
module sram_fifo_obuf
    import sram_fifo_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [DATA_WIDTH-1:0]     push_data,
    input  logic                      pop,
    output logic [DATA_WIDTH-1:0]     head_data,
    output logic [OBUF_CNT_WIDTH-1:0] count,
    output logic                      not_empty
);

    logic [DATA_WIDTH-1:0]     mem [OBUF_DEPTH];
    logic [OBUF_PTR_WIDTH-1:0] wr_idx;
    logic [OBUF_PTR_WIDTH-1:0] rd_idx;
    logic [OBUF_CNT_WIDTH-1:0] count_q;
    logic [OBUF_CNT_WIDTH-1:0] count_next;
    logic                      pop_ok;

    assign not_empty = (count_q != '0);
    assign pop_ok    = pop & not_empty;
    assign head_data = mem[rd_idx];
    assign count     = count_q;

    // A simultaneous push and pop leaves the occupancy unchanged.
    always_comb begin
        count_next = count_q;
        case ({push, pop_ok})
            2'b10:   count_next = count_q + OBUF_CNT_WIDTH'(1);
            2'b01:   count_next = count_q - OBUF_CNT_WIDTH'(1);
            default: count_next = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx  <= '0;
            rd_idx  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_idx <= obuf_next(wr_idx);
            end
            if (pop_ok) begin
                rd_idx <= obuf_next(rd_idx);
            end
            count_q <= count_next;
        end
    end

    // Data storage needs no reset: an entry is only visible after a push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/sram_1w1r_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sram_1w1r_fifo_ctrl
// Valid/ready streaming FIFO built on the 14x128 1-write/1-read OpenRAM macro.
// Port 0 of the macro takes writes, port 1 takes reads; both macro clocks are
// tied to clk. The macro registers its inputs at the posedge and accesses the
// array at the following negedge, so a read issued in cycle N is sampled at
// the posedge that starts cycle N+2. A 3-entry prefetch buffer absorbs that
// latency so the output can stream one word per cycle.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready/in_data  upstream stream (accept = in_valid & in_ready)
//   out_valid/out_ready/out_data downstream stream (pop = out_valid & out_ready)
//   level                      words accepted and not yet popped
//   sram_csb0/addr0/din0       macro write port (csb active low)
//   sram_csb1/addr1            macro read port (csb active low)
//   sram_dout1                 macro read data
// -----------------------------------------------------------------------------
module sram_1w1r_fifo_ctrl
    import sram_fifo_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [LEVEL_WIDTH-1:0] level,
    output logic                   sram_csb0,
    output logic [ADDR_WIDTH-1:0]  sram_addr0,
    output logic [DATA_WIDTH-1:0]  sram_din0,
    output logic                   sram_csb1,
    output logic [ADDR_WIDTH-1:0]  sram_addr1,
    input  logic [DATA_WIDTH-1:0]  sram_dout1
);

    // wr_ptr / rd_ptr    : next macro address to write / read
    // rd_avail           : words written to the macro but not yet issued for read
    // sram_used          : macro locations holding a word not yet captured;
    //                      a location is only reusable once its read data has
    //                      been captured into the prefetch buffer
    // p1                 : a read was latched by the macro at the last posedge
    //                      and its data is sampled at the next posedge
    logic [ADDR_WIDTH-1:0]     wr_ptr;
    logic [ADDR_WIDTH-1:0]     rd_ptr;
    logic [CNT_WIDTH-1:0]      rd_avail;
    logic [CNT_WIDTH-1:0]      sram_used;
    logic                      p1;
    logic [LEVEL_WIDTH-1:0]    level_q;

    logic [CNT_WIDTH-1:0]      rd_avail_next;
    logic [CNT_WIDTH-1:0]      sram_used_next;
    logic [LEVEL_WIDTH-1:0]    level_next;

    logic                      accept;
    logic                      pop;
    logic                      issue;
    logic                      capture;
    logic [OBUF_CNT_WIDTH:0]   obuf_committed;

    logic [OBUF_CNT_WIDTH-1:0] obuf_cnt;
    logic                      obuf_not_empty;
    logic [DATA_WIDTH-1:0]     obuf_head;

    // Handshakes. in_ready depends only on registers (and the reset pin) so
    // the upstream side never sees a combinational path from in_valid.
    always_comb begin
        in_ready = rst_n & (sram_used < CNT_WIDTH'(DEPTH));
        accept   = in_valid & in_ready;
        pop      = out_valid & out_ready;
        capture  = p1;
    end

    // Read issue: only start a read when the prefetch buffer is guaranteed to
    // have room for it, counting the entries already held plus the read
    // still in flight. Registered values only, so issue never depends on the
    // same-cycle pop.
    always_comb begin
        obuf_committed = {1'b0, obuf_cnt} + (OBUF_CNT_WIDTH + 1)'(p1);
        issue          = rst_n & (rd_avail != '0) &
                         (obuf_committed < (OBUF_CNT_WIDTH + 1)'(OBUF_DEPTH));
    end

    // Macro port drive. A word written here is committed at the next negedge,
    // one cycle before any read of it can reach the array, so no bypass path
    // is needed. Reads and writes never target the same address in the same
    // cycle: when both are active, rd_ptr trails wr_ptr by rd_avail, which is
    // neither 0 (no issue) nor DEPTH (no accept while the macro is full).
    always_comb begin
        sram_csb0  = ~accept;
        sram_addr0 = wr_ptr;
        sram_din0  = in_data;
        sram_csb1  = ~issue;
        sram_addr1 = rd_ptr;
    end

    // Counter updates. Each counter has one increment and one decrement
    // source; when both fire in the same cycle the value holds.
    always_comb begin
        rd_avail_next = rd_avail;
        case ({accept, issue})
            2'b10:   rd_avail_next = rd_avail + CNT_WIDTH'(1);
            2'b01:   rd_avail_next = rd_avail - CNT_WIDTH'(1);
            default: rd_avail_next = rd_avail;
        endcase

        sram_used_next = sram_used;
        case ({accept, capture})
            2'b10:   sram_used_next = sram_used + CNT_WIDTH'(1);
            2'b01:   sram_used_next = sram_used - CNT_WIDTH'(1);
            default: sram_used_next = sram_used;
        endcase

        level_next = level_q;
        case ({accept, pop})
            2'b10:   level_next = level_q + LEVEL_WIDTH'(1);
            2'b01:   level_next = level_q - LEVEL_WIDTH'(1);
            default: level_next = level_q;
        endcase
    end

    // Pointer and counter registers. DEPTH is a power of two, so the address
    // pointers wrap naturally. Resetting p1 drops any read in flight; its
    // data arrives from the macro but is never captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_avail  <= '0;
            sram_used <= '0;
            p1        <= 1'b0;
            level_q   <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            rd_avail  <= rd_avail_next;
            sram_used <= sram_used_next;
            p1        <= issue;
            level_q   <= level_next;
        end
    end

    // The read data is sampled at the posedge where p1 is set, before the
    // macro's output hold time expires and it starts driving X.
    sram_fifo_obuf u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (capture),
        .push_data (sram_dout1),
        .pop       (pop),
        .head_data (obuf_head),
        .count     (obuf_cnt),
        .not_empty (obuf_not_empty)
    );

    always_comb begin
        out_valid = obuf_not_empty;
        out_data  = obuf_head;
        level     = level_q;
    end

endmodule
